// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage with register file and ID/EX pipeline register.
// Optional feature (macro DECODE_BYPASS_EN): when defined, a same-cycle writeback to
// a register being read is forwarded into the read ports (write-through).
module decode_cycle #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } idex_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [4:0] rd_d;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];
  assign rd_d     = InstrD[11:7];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  // Main decoder: opcode -> control bundle; unknown opcodes become a NOP
  logic       reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0] imm_src_d, result_src_d, alu_op_d;
  always_comb begin
    reg_write_d  = 1'b0;
    imm_src_d    = 2'b00;
    alu_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    result_src_d = 2'b00;
    branch_d     = 1'b0;
    alu_op_d     = 2'b00;
    jump_d       = 1'b0;
    case (opcode)
      7'b0000011: begin // lw
        reg_write_d = 1'b1; alu_src_d = 1'b1; result_src_d = 2'b01;
      end
      7'b0100011: begin // sw
        imm_src_d = 2'b01; alu_src_d = 1'b1; mem_write_d = 1'b1;
      end
      7'b0110011: begin // R-type; immediate unused
        reg_write_d = 1'b1; alu_op_d = 2'b10;
      end
      7'b1100011: begin // beq
        imm_src_d = 2'b10; branch_d = 1'b1; alu_op_d = 2'b01;
      end
      7'b0010011: begin // I-type ALU
        reg_write_d = 1'b1; alu_src_d = 1'b1; alu_op_d = 2'b10;
      end
      7'b1101111: begin // jal
        reg_write_d = 1'b1; imm_src_d = 2'b11; result_src_d = 2'b10; jump_d = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: only register-register ops with funct7[5] select subtract
  logic [2:0] alu_control_d;
  always_comb begin
    alu_control_d = 3'b000;
    case (alu_op_d)
      2'b00: alu_control_d = 3'b000;
      2'b01: alu_control_d = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_control_d = (opcode[5] & funct7_5) ? 3'b001 : 3'b000;
          3'b010:  alu_control_d = 3'b101;
          3'b110:  alu_control_d = 3'b011;
          3'b111:  alu_control_d = 3'b010;
          default: alu_control_d = 3'b000;
        endcase
      end
      default: alu_control_d = 3'b000;
    endcase
  end

  // Immediate generator, sign-extended from InstrD[31]
  logic [XLEN-1:0] imm_ext_d;
  always_comb begin
    imm_ext_d = '0;
    case (imm_src_d)
      2'b00: imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      2'b01: imm_ext_d = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      2'b10: imm_ext_d = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                          InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11: imm_ext_d = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                          InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext_d = '0;
    endcase
  end

  // Register file storage; x0 is never written so it stays zero
  logic [XLEN-1:0] rf_q [NREG];
  logic            wb_en;
  assign wb_en = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[RDW] <= ResultW;
    end
  end

  // Asynchronous read ports, with optional forwarding of the in-flight writeback
  logic [XLEN-1:0] rd1_d, rd2_d;
  always_comb begin
    rd1_d = (Rs1D == 5'd0) ? '0 : rf_q[Rs1D];
    rd2_d = (Rs2D == 5'd0) ? '0 : rf_q[Rs2D];
`ifdef DECODE_BYPASS_EN
    if (wb_en && (RDW == Rs1D)) rd1_d = ResultW;
    if (wb_en && (RDW == Rs2D)) rd2_d = ResultW;
`endif
  end

  // Next ID/EX contents; a flush loads an all-zero NOP
  idex_t idex_d, idex_q;
  always_comb begin
    idex_d = '0;
    if (!FlushE) begin
      idex_d.reg_write   = reg_write_d;
      idex_d.mem_write   = mem_write_d;
      idex_d.jump        = jump_d;
      idex_d.branch      = branch_d;
      idex_d.alu_src     = alu_src_d;
      idex_d.result_src  = result_src_d;
      idex_d.alu_control = alu_control_d;
      idex_d.rd1         = rd1_d;
      idex_d.rd2         = rd2_d;
      idex_d.imm_ext     = imm_ext_d;
      idex_d.pc          = PCD;
      idex_d.pc_plus4    = PCPlus4D;
      idex_d.rd          = rd_d;
      idex_d.rs1         = Rs1D;
      idex_d.rs2         = Rs2D;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign RegWriteE   = idex_q.reg_write;
  assign MemWriteE   = idex_q.mem_write;
  assign JumpE       = idex_q.jump;
  assign BranchE     = idex_q.branch;
  assign ALUSrcE     = idex_q.alu_src;
  assign ResultSrcE  = idex_q.result_src;
  assign ALUControlE = idex_q.alu_control;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm_ext;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc_plus4;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: scoreboard bench for decode_cycle. Expected ID/EX contents are
// hand-derived per instruction, queued at drive time and popped after the edge.
module tb_decode_cycle;

  logic        clk, rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
  typedef struct {
    logic [9:0]  ctl;
    logic [31:0] rd1, rd2, imm, pc;
    logic        imm_vld;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] pc_r = 32'h100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [9:0] ctl, input logic [31:0] rd1, rd2,
                              input logic imm_vld, input logic [31:0] imm,
                              input logic [4:0] rd, rs1, rs2);
    exp_t e;
    e.ctl = ctl; e.rd1 = rd1; e.rd2 = rd2; e.imm_vld = imm_vld; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.pc = 32'h0;
    return e;
  endfunction

  // Drive one D-stage cycle, queue its expected E contents, compare after the edge
  task automatic step(input string tag, input logic [31:0] instr, input logic flush,
                      input logic wen, input logic [4:0] wrd, input logic [31:0] wdat,
                      input exp_t e);
    exp_t o;
    @(negedge clk);
    InstrD = instr; PCD = pc_r; PCPlus4D = pc_r + 32'd4;
    FlushE = flush; RegWriteW = wen; RDW = wrd; ResultW = wdat;
    e.pc = flush ? 32'h0 : pc_r;
    sb_q.push_back(e);
    pc_r = pc_r + 32'd4;
    @(posedge clk);
    #1;
    RegWriteW = 1'b0; FlushE = 1'b0;
    o = sb_q.pop_front();
    chk({tag, ".ctl"}, {22'h0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
                        ResultSrcE, ALUControlE}, {22'h0, o.ctl});
    chk({tag, ".rd1"}, RD1E, o.rd1);
    chk({tag, ".rd2"}, RD2E, o.rd2);
    if (o.imm_vld) chk({tag, ".imm"}, ImmExtE, o.imm);
    chk({tag, ".pc"}, PCE, o.pc);
    chk({tag, ".pc4"}, PCPlus4E, (o.pc == 32'h0) ? 32'h0 : o.pc + 32'd4);
    chk({tag, ".rd"}, {27'h0, RdE}, {27'h0, o.rd});
    chk({tag, ".rs1"}, {27'h0, Rs1E}, {27'h0, o.rs1});
    chk({tag, ".rs2"}, {27'h0, Rs2E}, {27'h0, o.rs2});
  endtask

  task automatic chk_e_zero(input string tag);
    chk({tag, ".ctl"}, {22'h0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
                        ResultSrcE, ALUControlE}, 32'h0);
    chk({tag, ".data"}, RD1E | RD2E | ImmExtE | PCE | PCPlus4E, 32'h0);
    chk({tag, ".idx"}, {17'h0, RdE, Rs1E, Rs2E}, 32'h0);
  endtask

  logic [31:0] byp_val;

  initial begin
    rst = 1'b0; InstrD = 32'h00500093; PCD = 32'h0; PCPlus4D = 32'h0;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0; FlushE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_e_zero("reset");
    chk("reset.rs1d", {27'h0, Rs1D}, 32'h0);
    chk("reset.rs2d", {27'h0, Rs2D}, 32'h5);
    @(negedge clk);
    rst = 1'b1;

    // addi x1,x0,5 right after reset release
    step("addi", 32'h00500093, 0, 0, 0, 0, mk(10'b10001_00_000, 0, 0, 1, 32'h5, 1, 0, 5));
    // illegal opcode while writing x5
    step("illegal", 32'h0000007F, 0, 1, 5, 32'hDEADBEEF,
         mk(10'b00000_00_000, 0, 0, 1, 32'h0, 0, 0, 0));
    step("add", 32'h005302B3, 0, 0, 0, 0,
         mk(10'b10000_00_000, 0, 32'hDEADBEEF, 0, 0, 5, 6, 5));
    // x0 write attempt, then read x0 on both ports
    step("x0wr", 32'h000003B3, 0, 1, 0, 32'h1234, mk(10'b10000_00_000, 0, 0, 0, 0, 7, 0, 0));
    step("x0rd", 32'h000003B3, 0, 0, 0, 0, mk(10'b10000_00_000, 0, 0, 0, 0, 7, 0, 0));
    step("sw", 32'hFE20AE23, 0, 0, 0, 0,
         mk(10'b01001_00_000, 0, 0, 1, 32'hFFFFFFFC, 28, 1, 2));
    step("beq", 32'hFE028CE3, 0, 0, 0, 0,
         mk(10'b00010_00_001, 32'hDEADBEEF, 0, 1, 32'hFFFFFFF8, 25, 5, 0));
    step("jal", 32'h001000EF, 0, 0, 0, 0, mk(10'b10100_10_000, 0, 0, 1, 32'h800, 1, 0, 1));
    step("lw", 32'h0000A183, 0, 0, 0, 0, mk(10'b10001_01_000, 0, 0, 1, 32'h0, 3, 1, 0));
    // flush together with a writeback of x6: bubble, but the write lands
    step("flush", 32'h0000A183, 1, 1, 6, 32'h600DF00D, mk(10'b0, 0, 0, 1, 0, 0, 0, 0));
    step("postflush", 32'h005302B3, 0, 0, 0, 0,
         mk(10'b10000_00_000, 32'h600DF00D, 32'hDEADBEEF, 0, 0, 5, 6, 5));
    step("sub", 32'h405302B3, 0, 0, 0, 0,
         mk(10'b10000_00_001, 32'h600DF00D, 32'hDEADBEEF, 0, 0, 5, 6, 5));
    step("slt", 32'h00532233, 0, 0, 0, 0,
         mk(10'b10000_00_101, 32'h600DF00D, 32'hDEADBEEF, 0, 0, 4, 6, 5));
    step("or", 32'h0062E4B3, 0, 0, 0, 0,
         mk(10'b10000_00_011, 32'hDEADBEEF, 32'h600DF00D, 0, 0, 9, 5, 6));
    step("andi", 32'hFFF07093, 0, 0, 0, 0,
         mk(10'b10001_00_010, 0, 0, 1, 32'hFFFFFFFF, 1, 0, 31));
    // I-type with bit 30 set must still add
    step("addi_b30", 32'h40000093, 0, 0, 0, 0,
         mk(10'b10001_00_000, 0, 0, 1, 32'h400, 1, 0, 0));

`ifdef DECODE_BYPASS_EN
    byp_val = 32'hA5A5A5A5;
`else
    byp_val = 32'h0;
`endif
    step("byp_same", 32'h00038413, 0, 1, 7, 32'hA5A5A5A5,
         mk(10'b10001_00_000, byp_val, 0, 1, 32'h0, 8, 7, 0));
    step("byp_next", 32'h00038413, 0, 0, 0, 0,
         mk(10'b10001_00_000, 32'hA5A5A5A5, 0, 1, 32'h0, 8, 7, 0));

    // Asynchronous reset mid-cycle clears E outputs and the register file
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_e_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("rf_cleared", 32'h005302B3, 0, 0, 0, 0, mk(10'b10000_00_000, 0, 0, 0, 0, 5, 6, 5));

    chk("sb_empty", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Second stage of the 5-stage RV32I pipeline; consumes the IF/ID outputs of the fetch stage (instruction, PC, PC+4).
- Decodes control signals and generates the sign-extended immediate.
- Holds the 32x32 register file, whose write port is driven from writeback.
- Registers everything into the ID/EX pipeline register, with flush support for branch recovery and load-use bubbles.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count; x0 is hardwired to zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction from IF/ID.
- PCD  in  32  PC from IF/ID.
- PCPlus4D  in  32  PC+4 from IF/ID.
- RegWriteW  in  1  writeback write enable.
- RDW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- FlushE  in  1  clears ID/EX (bubble insert).
- Rs1D, Rs2D  out  5 each  combinational source fields, for the hazard unit.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered controls.
- ResultSrcE  out  2  00=ALU, 01=memory, 10=PC+4.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered data.
- RdE, Rs1E, Rs2E  out  5 each  registered register indices.

Behaviour:
- Reset is asynchronous, active-low, on rst. While rst=0:
  - all E outputs are 0;
  - all register-file entries are 0;
  - Rs1D/Rs2D still follow InstrD.
- Field extraction: Rs1D=InstrD[19:15], Rs2D=InstrD[24:20], Rd=InstrD[11:7].
- Main decoder, by opcode. Fields are RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump.
  - 0000011 lw: 1/00/1/0/01/0/00/0
  - 0100011 sw: 0/01/1/1/00/0/00/0
  - 0110011 R-type: 1/xx/0/0/00/0/10/0
  - 1100011 beq: 0/10/0/0/00/1/01/0
  - 0010011 I-ALU: 1/00/1/0/00/0/10/0
  - 1101111 jal: 1/11/0/0/10/0/00/1
  - Any other opcode decodes as a NOP (all controls 0).
- ALU decoder:
  - ALUOp 00 -> add.
  - ALUOp 01 -> sub.
  - ALUOp 10, funct3 000 -> sub if (opcode[5] & funct7[5]), else add.
  - ALUOp 10, funct3 010 -> slt; 110 -> or; 111 -> and.
  - ALUOp 10, any other funct3 -> add.
- Immediate generator (all results sign-extended from InstrD[31]):
  - ImmSrc 00 (I-type): InstrD[31:20].
  - ImmSrc 01 (S-type): {InstrD[31:25], InstrD[11:7]}.
  - ImmSrc 10 (B-type): {[31], [7], [30:25], [11:8], 0}.
  - ImmSrc 11 (J-type): {[31], [19:12], [20], [30:21], 0}.
- Register file:
  - Two asynchronous read ports.
  - Synchronous write on the rising clk edge when RegWriteW=1 and RDW!=0.
  - Writes to x0 are ignored; reads of x0 always return 0.
- ID/EX register, updated on the rising edge. Priority: rst=0 > FlushE=1 (all E outputs to 0, a true NOP) > normal load.
  - Latency: D-stage values appear at E outputs 1 cycle later.
- Boundary conditions:
  - Reset deasserted mid-stream: the first post-reset edge loads whatever is on InstrD.
  - FlushE and a writeback to the register file in the same cycle: the write still commits.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: a read whose index equals RDW while RegWriteW=1 and RDW!=0 returns ResultW in the same cycle (write-through). The ID/EX register therefore captures the new value.
- Undefined: reads return the stored value. The hazard unit must cover the one-cycle WB->ID hazard.

Test Plan:
- Reset: hold rst=0 with InstrD=0x00500093 -> all E outputs 0, Rs1D=0; release rst -> after 1 edge RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1.
- Register writeback: write x5=0xDEADBEEF, then InstrD=0x005302B3 (add x5,x6,x5) -> RD2E=0xDEADBEEF, ALUControlE=000. Write x0=0x1234 -> reads of x0 return 0.
- Immediates:
  - sw x2,-4(x1) (0xFE20AE23) -> ImmExtE=0xFFFFFFFC, MemWriteE=1.
  - beq with offset -8 -> ImmExtE=0xFFFFFFF8, BranchE=1, ALUControlE=001.
  - jal offset 0x800 -> ImmExtE=0x800, JumpE=1, ResultSrcE=10.
- Flush: load lw x3,0(x1), assert FlushE for one cycle -> all E outputs 0 that cycle; the next instruction then loads normally.
- Bypass, same cycle: RegWriteW=1, RDW=7, ResultW=0xA5A5A5A5, InstrD reads x7 -> RD1E=0xA5A5A5A5 with DECODE_BYPASS_EN defined, and the old value (0) without it.
- Illegal opcode 0x0000007F -> all controls 0; sub (funct7[5]=1, opcode 0110011) -> ALUControlE=001; slt -> 101.
